// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser (even parity bit added when UART_TX_PARITY_EN is defined).
// Latency: a push into an empty FIFO while idle makes tx fall 2 clocks later; one frame is 10*DIV (11*DIV) clocks.
// Backpressure: tx_rdy = !full; a strobe while full drops the byte and sets sticky overflow.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_rdy,
    output logic       tx,
    output logic       tx_rdy,
    output logic       busy,
    output logic       overflow
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          full, empty, push, pop;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    // full is taken from the registered count, so a same-cycle pop never frees a slot for a push
    assign full  = (count_q == NW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = din_rdy & ~full;
    assign pop   = (state_q == IDLE) & ~empty;

    assign tx       = tx_q;
    assign tx_rdy   = ~full;
    assign busy     = (state_q != IDLE) | ~empty;
    assign overflow = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + NW'(push) - NW'(pop);
        overflow_d = overflow_q | (din_rdy & full);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: random and directed byte bursts; a line monitor decodes frames against a queue of expected bytes.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ   = 16;
    localparam int BAUD       = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_rdy;
    logic       tx, tx_rdy, busy, overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] burst_q[$];
    int         fall_q[$];
    int         starts[$];
    int         rdy_after[16];
    int         ovf_after[16];
    int         push_cyc;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .din_rdy(din_rdy),
        .tx(tx), .tx_rdy(tx_rdy), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Line monitor: records every high->low transition and decodes frames by mid-bit sampling
    logic       prev_tx = 1'b1;
    bit         m_active = 1'b0;
    int         m_cnt;
    logic [7:0] m_byte;
    logic       m_par;
    logic [7:0] e;
    always @(negedge clk) begin
        if (prev_tx === 1'b1 && tx === 1'b0) fall_q.push_back(cyc);
        if (rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt % DIV == DIV / 2) begin
                int bi;
                bi = m_cnt / DIV;
                if (bi == 0) check_eq("start_bit", int'(tx), 0);
                else if (bi <= 8) m_byte[bi-1] = tx;
                else if (bi < NB - 1) m_par = tx;
                else begin
                    check_eq("stop_bit", int'(tx), 1);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_frame", int'(m_byte), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("frame_byte", int'(m_byte), int'(e));
`ifdef UART_TX_PARITY_EN
                        check_eq("parity_bit", int'(m_par), int'(^e));
`endif
                    end
                    m_active = 1'b0;
                end
            end
        end else if (prev_tx === 1'b1 && tx === 1'b0) begin
            m_active = 1'b1;
            m_cnt    = 0;
        end
        prev_tx = tx;
    end

    // From an idle, empty FIFO the first byte is popped the edge after its push,
    // so a run of consecutive strobes has FIFO_DEPTH+1 bytes accepted.
    task automatic do_burst(input bit track);
        for (int i = 0; i < burst_q.size(); i++) begin
            din     = burst_q[i];
            din_rdy = 1'b1;
            if (track && i < FIFO_DEPTH + 1) exp_q.push_back(burst_q[i]);
            tick;
            if (i == 0) push_cyc = cyc;
            rdy_after[i] = int'(tx_rdy);
            ovf_after[i] = int'(overflow);
        end
        din_rdy = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            tick;
            n++;
        end
        check_eq(name, int'(busy), 0);
    endtask

    task automatic extract_starts;
        starts.delete();
        foreach (fall_q[i])
            if (starts.size() == 0 || fall_q[i] >= starts[$] + FL) starts.push_back(fall_q[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, drop_cyc, target;
        rst = 1'b1; din = '0; din_rdy = 1'b0;
        repeat (3) tick;
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            tick;
            check_eq("idle_outputs", int'({tx, tx_rdy, busy, overflow}), 4'b1100);
        end

        // single byte: start latency and busy drop
        fall_q.delete();
        burst_q = '{8'hA5};
        do_burst(1'b1);
        n = 0;
        while (fall_q.size() == 0 && n < 20) begin tick; n++; end
        check_eq("start_latency", fall_q.size() > 0 ? fall_q[0] - push_cyc : -1, 2);
        n = 0;
        while (busy && n < 400) begin tick; n++; end
        drop_cyc = cyc;
        check_eq("busy_drop", fall_q.size() > 0 ? drop_cyc - fall_q[0] : -1, FL - 1);
        check_eq("tx_at_busy_drop", int'(tx), 1);

        // queued burst: one idle clock between frames
        fall_q.delete();
        burst_q = '{8'h00, 8'hFF, 8'h55};
        do_burst(1'b1);
        wait_idle("burst_drain");
        extract_starts();
        check_eq("burst_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check_eq("burst_gap0", starts[1] - starts[0], FL + 1);
            check_eq("burst_gap1", starts[2] - starts[1], FL + 1);
        end

        // parity-relevant pair
        fall_q.delete();
        burst_q = '{8'h07, 8'h03};
        do_burst(1'b1);
        wait_idle("pair_drain");
        extract_starts();
        check_eq("pair_frames", starts.size(), 2);
        if (starts.size() == 2) check_eq("pair_gap", starts[1] - starts[0], FL + 1);

        // randomized bursts up to FIFO_DEPTH+1 long from idle
        for (int r = 0; r < 10; r++) begin
            int len;
            len = $urandom_range(1, FIFO_DEPTH + 1);
            burst_q.delete();
            for (int i = 0; i < len; i++) burst_q.push_back(8'($urandom));
            do_burst(1'b1);
            check_eq("rand_rdy_last", rdy_after[len-1], len == FIFO_DEPTH + 1 ? 0 : 1);
            wait_idle("rand_drain");
            repeat ($urandom_range(0, 3)) tick;
        end
        check_eq("rand_overflow", int'(overflow), 0);

        // full / overflow
        burst_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        do_burst(1'b1);
        for (int i = 0; i < 4; i++) check_eq("ovf_rdy_early", rdy_after[i], 1);
        check_eq("ovf_rdy_full", rdy_after[4], 0);
        check_eq("ovf_before_drop", ovf_after[4], 0);
        check_eq("ovf_after_drop", ovf_after[5], 1);
        wait_idle("ovf_drain");
        check_eq("ovf_sticky", int'(overflow), 1);
        check_eq("ovf_rdy_drained", int'(tx_rdy), 1);

        // reset during data bit 3 of 0x3C with two bytes queued
        fall_q.delete();
        burst_q = '{8'h3C, 8'h11, 8'h22};
        do_burst(1'b0);
        n = 0;
        while (fall_q.size() == 0 && n < 20) begin tick; n++; end
        check_eq("rst_frame_started", fall_q.size(), 1);
        target = (fall_q.size() > 0 ? fall_q[0] : cyc) + 4 * DIV + DIV / 2;
        while (cyc < target) tick;
        check_eq("rst_bit3", int'(tx), 1);
        rst = 1'b1;
        tick;
        check_eq("rst_tx", int'(tx), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_rdy", int'(tx_rdy), 1);
        check_eq("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        fall_q.delete();
        repeat (3 * FL) tick;
        check_eq("rst_no_frames", fall_q.size(), 0);
        check_eq("rst_still_idle", int'(busy), 0);

        check_eq("leftover_expected", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
